// File: rtl/ipg_tx_axis_arbiter.sv
// Round-robin, packet-atomic arbiter of PORTS AXI-stream requesters onto one 10G MAC TX port (optional watchdog: IPG_ARB_WATCHDOG_EN).
// Latency: grant registered one cycle after a request; data then passes combinationally; one idle cycle between packets.
// Backpressure: m_axis_tready is routed straight to the granted port's s_axis_tready; all other readies stay low.
module ipg_tx_axis_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int USER_WIDTH      = 1,
    parameter int PORTS           = 2,
    parameter int WATCHDOG_CYCLES = 16
) (
    input  logic                            tx_clk,
    input  logic                            tx_rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic [PORTS-1:0]                s_axis_tvalid,
    output logic [PORTS-1:0]                s_axis_tready,
    input  logic [PORTS-1:0]                s_axis_tlast,
    input  logic [PORTS*USER_WIDTH-1:0]     s_axis_tuser,
    input  logic [PORTS*8-1:0]              s_ifg_delay,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [USER_WIDTH-1:0]           m_axis_tuser,
    output logic [7:0]                      ifg_delay,
    output logic [PORTS-1:0]                grant,
    output logic                            abort_pulse
);

    localparam int IDXW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Parameter sanity: the arbiter is only sized and verified for 2..4 requesters.
    if (PORTS < 2 || PORTS > 4 || WATCHDOG_CYCLES < 1) begin : g_param_check
        $error("ipg_tx_axis_arbiter: PORTS must be 2..4 and WATCHDOG_CYCLES >= 1");
    end

    state_t                 r_state;
    logic [IDXW-1:0]        r_gidx;
    logic [PORTS-1:0]       r_grant;
    logic [IDXW-1:0]        r_rr_ptr;
    logic [7:0]             r_ifg;

    // Per-port views of the packed input buses.
    logic [DATA_WIDTH-1:0]  w_tdata_arr [PORTS];
    logic [KEEP_WIDTH-1:0]  w_tkeep_arr [PORTS];
    logic [USER_WIDTH-1:0]  w_tuser_arr [PORTS];
    logic [7:0]             w_ifg_arr   [PORTS];

    logic                   w_req_any;
    logic [IDXW-1:0]        w_req_idx;
    logic [IDXW-1:0]        w_cand;
    logic [IDXW-1:0]        w_next_ptr;
    logic                   w_g_vld;
    logic                   w_g_last;

    for (genvar k = 0; k < PORTS; k++) begin : g_unpack
        assign w_tdata_arr[k] = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_tkeep_arr[k] = s_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH];
        assign w_tuser_arr[k] = s_axis_tuser[k*USER_WIDTH +: USER_WIDTH];
        assign w_ifg_arr[k]   = s_ifg_delay[k*8 +: 8];
    end

    assign w_g_vld    = s_axis_tvalid[r_gidx];
    assign w_g_last   = s_axis_tlast[r_gidx];
    assign w_next_ptr = (w_req_idx == IDXW'(PORTS - 1)) ? '0 : w_req_idx + 1'b1;

    assign grant      = r_grant;
    assign ifg_delay  = r_ifg;

    // Round-robin pick: scan from rr_ptr upward, nearest requester wins (descending loop, last hit is nearest).
    always_comb begin
        w_req_any = 1'b0;
        w_req_idx = '0;
        w_cand    = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            w_cand = IDXW'((int'(r_rr_ptr) + i) % PORTS);
            if (s_axis_tvalid[w_cand]) begin
                w_req_any = 1'b1;
                w_req_idx = w_cand;
            end
        end
    end

    // Output steering: pass-through of the owner in XFER, synthetic abort beat / silent drain otherwise.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = '0;
        case (r_state)
            XFER: begin
                m_axis_tvalid = w_g_vld;
                m_axis_tdata  = w_tdata_arr[r_gidx];
                m_axis_tkeep  = w_tkeep_arr[r_gidx];
                m_axis_tlast  = w_g_last;
                m_axis_tuser  = w_tuser_arr[r_gidx];
                s_axis_tready = r_grant & {PORTS{m_axis_tready}};
            end
`ifdef IPG_ARB_WATCHDOG_EN
            ABORT: begin
                // Terminate the stalled frame towards the MAC and flag it bad.
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tkeep  = KEEP_WIDTH'(1);
                m_axis_tuser  = USER_WIDTH'(1);
            end
            DRAIN: begin
                s_axis_tready = r_grant;
            end
`endif
            default: ;
        endcase
    end

`ifdef IPG_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);

    logic [WDW-1:0]         r_wd_cnt;
    logic                   r_abort_pulse;

    assign abort_pulse = r_abort_pulse;

    // Arbitration FSM with mid-packet stall watchdog.
    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            r_state       <= IDLE;
            r_gidx        <= '0;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_ifg         <= 8'd12;
            r_wd_cnt      <= '0;
            r_abort_pulse <= 1'b0;
        end else begin
            r_abort_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_wd_cnt <= '0;
                    if (w_req_any) begin
                        r_state  <= XFER;
                        r_gidx   <= w_req_idx;
                        r_grant  <= PORTS'(1) << w_req_idx;
                        r_rr_ptr <= w_next_ptr;
                        r_ifg    <= w_ifg_arr[w_req_idx];
                    end
                end
                XFER: begin
                    if (w_g_vld && m_axis_tready && w_g_last) begin
                        r_state  <= IDLE;
                        r_grant  <= '0;
                        r_wd_cnt <= '0;
                    end else if (!w_g_vld) begin
                        if (r_wd_cnt == WDW'(WATCHDOG_CYCLES - 1)) begin
                            r_state       <= ABORT;
                            r_abort_pulse <= 1'b1;
                            r_wd_cnt      <= '0;
                        end else begin
                            r_wd_cnt <= r_wd_cnt + 1'b1;
                        end
                    end else begin
                        r_wd_cnt <= '0;
                    end
                end
                ABORT: begin
                    if (m_axis_tready) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Owner keeps its grant until the rest of its frame is swallowed.
                    if (w_g_vld && w_g_last) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`else
    assign abort_pulse = 1'b0;

    // Arbitration FSM; a stalled owner simply holds the output indefinitely.
    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            r_state  <= IDLE;
            r_gidx   <= '0;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_ifg    <= 8'd12;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_state  <= XFER;
                        r_gidx   <= w_req_idx;
                        r_grant  <= PORTS'(1) << w_req_idx;
                        r_rr_ptr <= w_next_ptr;
                        r_ifg    <= w_ifg_arr[w_req_idx];
                    end
                end
                XFER: begin
                    if (w_g_vld && m_axis_tready && w_g_last) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ipg_tx_axis_arbiter.sv
// Bench for ipg_tx_axis_arbiter: queued per-port sources, scoreboard on the MAC side, per-scenario cycle checks.
// Inputs change 1 time unit after the rising edge; handshakes are sampled 1 unit before it.
// Builds with or without IPG_ARB_WATCHDOG_EN; the stall scenario adapts its expectations.
module tb_ipg_tx_axis_arbiter;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 1;
    localparam int NP = 2;

    logic             tx_clk = 1'b0;
    logic             tx_rst_n;
    logic [NP*DW-1:0] s_axis_tdata;
    logic [NP*KW-1:0] s_axis_tkeep;
    logic [NP-1:0]    s_axis_tvalid;
    logic [NP-1:0]    s_axis_tready;
    logic [NP-1:0]    s_axis_tlast;
    logic [NP*UW-1:0] s_axis_tuser;
    logic [NP*8-1:0]  s_ifg_delay;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic [UW-1:0]    m_axis_tuser;
    logic [7:0]       ifg_delay;
    logic [NP-1:0]    grant;
    logic             abort_pulse;

    ipg_tx_axis_arbiter #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .PORTS(NP), .WATCHDOG_CYCLES(16)
    ) dut (
        .tx_clk(tx_clk), .tx_rst_n(tx_rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_ifg_delay(s_ifg_delay),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .ifg_delay(ifg_delay), .grant(grant), .abort_pulse(abort_pulse)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    // kind: 0 = real beat, 1 = one idle cycle, 2 = valid for one cycle then withdrawn
    typedef struct {
        beat_t b;
        int    kind;
    } drv_t;

    drv_t  pq [NP][$];
    beat_t exp_q [$];
    int    checks   = 0;
    int    failures = 0;
    bit    shown [NP];
    bit    hs    [NP];
    beat_t mon_got;
    beat_t mon_exp;

    function automatic beat_t mk(input int p, input int id, input int i, input bit last);
        beat_t b;
        b.data = {16'(16'hA500 + id), 16'(p), 16'(i), 16'(id * 37 + i * 5 + p)};
        b.keep = last ? 8'h0F : 8'hFF;
        b.last = last;
        b.user = UW'((id + i) % 2);
        return b;
    endfunction

    task automatic src_beat(input int p, input beat_t b);
        drv_t e;
        e.b    = b;
        e.kind = 0;
        pq[p].push_back(e);
    endtask

    task automatic src_gap(input int p, input int kind, input int n);
        drv_t e;
        e.b    = '0;
        e.kind = kind;
        for (int i = 0; i < n; i++) pq[p].push_back(e);
    endtask

    task automatic src_pkt(input int p, input int id, input int n, input bit expect_out);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = mk(p, id, i, i == n - 1);
            src_beat(p, b);
            if (expect_out) exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(output int remaining);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pq[0].size() != 0 || pq[1].size() != 0) && n < 300) begin
            @(negedge tx_clk);
            n++;
        end
        remaining = exp_q.size() + pq[0].size() + pq[1].size();
        repeat (2) @(negedge tx_clk);
    endtask

    // Requester model: one queue per port, advances on handshake (or after one cycle for gap entries).
    initial begin
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        for (int p = 0; p < NP; p++) shown[p] = 1'b0;
        forever begin
            @(negedge tx_clk);
            #4;
            for (int p = 0; p < NP; p++) hs[p] = s_axis_tvalid[p] && s_axis_tready[p];
            @(posedge tx_clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (shown[p] && pq[p].size() > 0 && (pq[p][0].kind != 0 || hs[p]))
                    void'(pq[p].pop_front());
                if (pq[p].size() == 0) begin
                    s_axis_tvalid[p] = 1'b0;
                    shown[p]         = 1'b0;
                end else begin
                    shown[p]                = 1'b1;
                    s_axis_tvalid[p]        = (pq[p][0].kind != 1);
                    s_axis_tdata[p*DW +: DW] = pq[p][0].b.data;
                    s_axis_tkeep[p*KW +: KW] = pq[p][0].b.keep;
                    s_axis_tlast[p]         = pq[p][0].b.last;
                    s_axis_tuser[p*UW +: UW] = pq[p][0].b.user;
                end
            end
        end
    end

    // MAC-side scoreboard: every accepted output beat must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge tx_clk);
            #4;
            if (m_axis_tvalid && m_axis_tready) begin
                mon_got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got=%h required=none t=%0t", mon_got, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        failures++;
                        $display("FAIL out_beat got=%h required=%h t=%0t", mon_got, mon_exp, $time);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        tx_rst_n      = 1'b0;
        m_axis_tready = 1'b1;
        s_ifg_delay   = {8'd20, 8'd12};
        repeat (3) @(posedge tx_clk);
        @(negedge tx_clk);
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b required=00", grant); end
        checks++; if (ifg_delay !== 8'd12) begin failures++; $display("FAIL reset_ifg got=%0d required=12", ifg_delay); end
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b required=0", m_axis_tvalid); end
        checks++; if (s_axis_tready !== 2'b00) begin failures++; $display("FAIL reset_tready got=%b required=00", s_axis_tready); end
        checks++; if (abort_pulse !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b required=0", abort_pulse); end
        @(posedge tx_clk);
        #1 tx_rst_n = 1'b1;
    endtask

    // Both ports request together: port0 first, one bubble, then port1; ifg follows the owner.
    task automatic test_two_port();
        logic [1:0] g_exp [7];
        logic       v_exp [7];
        logic [7:0] f_exp [7];
        int         rem;
        g_exp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        v_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        f_exp = '{8'd12, 8'd12, 8'd12, 8'd12, 8'd20, 8'd20, 8'd20};
        @(negedge tx_clk);
        s_ifg_delay = {8'd20, 8'd12};
        src_pkt(0, 1, 2, 1'b1);
        src_pkt(1, 2, 2, 1'b1);
        for (int c = 0; c < 7; c++) begin
            @(negedge tx_clk);
            checks++; if (grant !== g_exp[c]) begin failures++; $display("FAIL two_port_grant c=%0d got=%b required=%b", c, grant, g_exp[c]); end
            checks++; if (m_axis_tvalid !== v_exp[c]) begin failures++; $display("FAIL two_port_tvalid c=%0d got=%b required=%b", c, m_axis_tvalid, v_exp[c]); end
            checks++; if (ifg_delay !== f_exp[c]) begin failures++; $display("FAIL two_port_ifg c=%0d got=%0d required=%0d", c, ifg_delay, f_exp[c]); end
        end
        wait_drain(rem);
        checks++; if (rem !== 0) begin failures++; $display("FAIL two_port_drain got=%0d required=0", rem); end
    endtask

    // MAC stalls for 3 cycles on beat 1: data held, source not acknowledged.
    task automatic test_backpressure();
        beat_t b1;
        int    rem;
        b1 = mk(0, 3, 1, 1'b0);
        @(negedge tx_clk);
        src_pkt(0, 3, 4, 1'b1);
        @(negedge tx_clk);
        @(negedge tx_clk);
        @(posedge tx_clk);
        #1 m_axis_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge tx_clk);
            checks++; if (m_axis_tdata !== b1.data) begin failures++; $display("FAIL bp_tdata c=%0d got=%h required=%h", c, m_axis_tdata, b1.data); end
            checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid c=%0d got=%b required=1", c, m_axis_tvalid); end
            checks++; if (s_axis_tready !== 2'b00) begin failures++; $display("FAIL bp_s_tready c=%0d got=%b required=00", c, s_axis_tready); end
        end
        @(posedge tx_clk);
        #1 m_axis_tready = 1'b1;
        wait_drain(rem);
        checks++; if (rem !== 0) begin failures++; $display("FAIL bp_drain got=%0d required=0", rem); end
    endtask

    // Single-beat packets on both ports: one XFER cycle each, strict alternation starting at port1.
    task automatic test_single_beat_rr();
        logic [1:0] g_exp [9];
        logic       v_exp [9];
        int         rem;
        g_exp = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        v_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge tx_clk);
        src_pkt(1, 11, 1, 1'b1);
        src_pkt(0, 12, 1, 1'b1);
        src_pkt(1, 13, 1, 1'b1);
        src_pkt(0, 14, 1, 1'b1);
        for (int c = 0; c < 9; c++) begin
            @(negedge tx_clk);
            checks++; if (grant !== g_exp[c]) begin failures++; $display("FAIL rr_grant c=%0d got=%b required=%b", c, grant, g_exp[c]); end
            checks++; if (m_axis_tvalid !== v_exp[c]) begin failures++; $display("FAIL rr_tvalid c=%0d got=%b required=%b", c, m_axis_tvalid, v_exp[c]); end
        end
        wait_drain(rem);
        checks++; if (rem !== 0) begin failures++; $display("FAIL rr_drain got=%0d required=0", rem); end
    endtask

    // Port1 raises valid for one cycle during port0's packet and withdraws: never served.
    task automatic test_no_latch();
        logic [1:0] g_exp [7];
        int         rem;
        g_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        @(negedge tx_clk);
        src_pkt(0, 5, 3, 1'b1);
        src_gap(1, 1, 1);
        src_gap(1, 2, 1);
        for (int c = 0; c < 7; c++) begin
            @(negedge tx_clk);
            checks++; if (grant !== g_exp[c]) begin failures++; $display("FAIL nolatch_grant c=%0d got=%b required=%b", c, grant, g_exp[c]); end
            checks++; if (s_axis_tready !== g_exp[c]) begin failures++; $display("FAIL nolatch_tready c=%0d got=%b required=%b", c, s_axis_tready, g_exp[c]); end
        end
        wait_drain(rem);
        checks++; if (rem !== 0) begin failures++; $display("FAIL nolatch_drain got=%0d required=0", rem); end
    endtask

    // Reset during the 4th beat of an 8-beat packet; afterwards rr restarts at port0.
    task automatic test_reset_midpacket();
        beat_t b0;
        beat_t b3;
        int    rem;
        b0 = mk(0, 6, 0, 1'b0);
        b3 = mk(0, 6, 3, 1'b0);
        @(negedge tx_clk);
        s_ifg_delay = {8'd20, 8'd33};
        src_pkt(0, 6, 8, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 6, i, 1'b0));
        @(negedge tx_clk);
        @(negedge tx_clk);
        checks++; if (ifg_delay !== 8'd33) begin failures++; $display("FAIL rstmid_ifg_load got=%0d required=33", ifg_delay); end
        checks++; if (m_axis_tdata !== b0.data) begin failures++; $display("FAIL rstmid_beat0 got=%h required=%h", m_axis_tdata, b0.data); end
        @(negedge tx_clk);
        @(negedge tx_clk);
        @(posedge tx_clk);
        #1 tx_rst_n = 1'b0;
        @(negedge tx_clk);
        checks++; if (m_axis_tdata !== b3.data) begin failures++; $display("FAIL rstmid_beat3 got=%h required=%h", m_axis_tdata, b3.data); end
        pq[0].delete();
        @(negedge tx_clk);
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rstmid_grant got=%b required=00", grant); end
        checks++; if (ifg_delay !== 8'd12) begin failures++; $display("FAIL rstmid_ifg got=%0d required=12", ifg_delay); end
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_tvalid got=%b required=0", m_axis_tvalid); end
        checks++; if (s_axis_tready !== 2'b00) begin failures++; $display("FAIL rstmid_tready got=%b required=00", s_axis_tready); end
        @(posedge tx_clk);
        #1 tx_rst_n = 1'b1;
        @(negedge tx_clk);
        src_pkt(0, 8, 1, 1'b1);
        src_pkt(1, 7, 1, 1'b1);
        @(negedge tx_clk);
        @(negedge tx_clk);
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rstmid_rr got=%b required=01", grant); end
        wait_drain(rem);
        checks++; if (rem !== 0) begin failures++; $display("FAIL rstmid_drain got=%0d required=0", rem); end
    endtask

    // Port0 goes silent for 20 cycles mid-packet while port1 waits.
    task automatic test_stall();
        beat_t ab;
        int    pulses;
        int    exp_pulses;
        int    rem;
        ab      = '0;
        ab.keep = 8'h01;
        ab.last = 1'b1;
        ab.user = UW'(1);
        pulses  = 0;
        @(negedge tx_clk);
        src_beat(0, mk(0, 9, 0, 1'b0));
        src_beat(0, mk(0, 9, 1, 1'b0));
        src_gap(0, 1, 20);
        src_beat(0, mk(0, 9, 2, 1'b0));
        src_beat(0, mk(0, 9, 3, 1'b1));
        exp_q.push_back(mk(0, 9, 0, 1'b0));
        exp_q.push_back(mk(0, 9, 1, 1'b0));
`ifdef IPG_ARB_WATCHDOG_EN
        exp_pulses = 1;
        exp_q.push_back(ab);
`else
        exp_pulses = 0;
        exp_q.push_back(mk(0, 9, 2, 1'b0));
        exp_q.push_back(mk(0, 9, 3, 1'b1));
`endif
        src_pkt(1, 10, 2, 1'b1);
        for (int c = 0; c < 60; c++) begin
            @(negedge tx_clk);
            if (c == 10) begin
                checks++; if (grant !== 2'b01) begin failures++; $display("FAIL stall_grant_hold got=%b required=01", grant); end
            end
            if (abort_pulse === 1'b1) begin
                pulses++;
                checks++; if ({m_axis_tvalid, m_axis_tlast, s_axis_tready} !== 4'b1100) begin
                    failures++; $display("FAIL abort_beat_ctrl got=%b required=1100", {m_axis_tvalid, m_axis_tlast, s_axis_tready});
                end
            end
        end
        checks++; if (pulses !== exp_pulses) begin failures++; $display("FAIL stall_abort_pulses got=%0d required=%0d", pulses, exp_pulses); end
        wait_drain(rem);
        checks++; if (rem !== 0) begin failures++; $display("FAIL stall_drain got=%0d required=0", rem); end
    endtask

    initial begin
        test_reset();
        test_two_port();
        test_backpressure();
        test_single_beat_rr();
        test_no_latch();
        test_reset_midpacket();
        test_stall();
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL final_scoreboard got=%0d required=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ipg_tx_axis_arbiter.md
IPG_TX_AXIS_ARBITER -- requirements
Module: ipg_tx_axis_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, tdata width.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have parameter USER_WIDTH, default 1, tuser width; bit 0 is the bad-frame flag.
REQ-004 SHALL have parameter PORTS, default 2, legal range 2..4, number of requesters.
REQ-005 SHALL have parameter WATCHDOG_CYCLES, default 16, mid-packet stall limit.
REQ-006 SHALL have ports:
- tx_clk  in  1  single clock.
- tx_rst_n  in  1  synchronous, active-low reset.
- s_axis_tdata  in  PORTS*DATA_WIDTH  packed requester data; port k at slice k.
- s_axis_tkeep  in  PORTS*KEEP_WIDTH  packed keep.
- s_axis_tvalid  in  PORTS  per-port valid.
- s_axis_tready  out  PORTS  per-port ready.
- s_axis_tlast  in  PORTS  per-port last.
- s_axis_tuser  in  PORTS*USER_WIDTH  packed user.
- s_ifg_delay  in  PORTS*8  per-port IFG request.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  to the 10G MAC TX AXI-stream port.
- ifg_delay  out  8  MAC ifg_delay.
- grant  out  PORTS  one-hot current owner; 0 when idle.
- abort_pulse  out  1  one-cycle strobe on watchdog abort.

Function
REQ-007 SHALL implement states IDLE, XFER, ABORT, DRAIN.
REQ-008 IDLE SHALL drive m_axis_tvalid=0, all s_axis_tready=0, grant=0.
REQ-009 IDLE with any s_axis_tvalid high SHALL register a grant, round-robin from rr_ptr (last granted+1 mod PORTS), and SHALL enter XFER next cycle; request at cycle N allows the first beat at N+1.
REQ-010 On grant, ifg_delay SHALL load s_ifg_delay[granted] and hold until the next grant.
REQ-011 XFER SHALL pass the granted port combinationally: m_axis_* = s_axis_*[g], s_axis_tready[g]=m_axis_tready, other readies 0.
REQ-012 Grant SHALL be packet-atomic: held until a handshake with s_axis_tlast[g]=1, then IDLE; this leaves exactly one bubble cycle between packets.
REQ-013 rr_ptr SHALL update to g+1 mod PORTS at grant time.
REQ-014 A packet with tlast on its first beat SHALL take one XFER cycle if m_axis_tready=1.
REQ-015 tvalid deasserted by a non-granted port SHALL have no effect; requests are not latched.

Reset
REQ-016 On tx_rst_n=0 at a tx_clk edge: state=IDLE, rr_ptr=0, grant=0, ifg_delay=8'd12, m_axis_tvalid=0, s_axis_tready=0, abort_pulse=0, watchdog count=0.
REQ-017 Reset asserted mid-packet SHALL take effect at that edge with no tlast emitted.

Configuration
REQ-018 Macro IPG_ARB_WATCHDOG_EN defined: in XFER, the counter SHALL increment each cycle s_axis_tvalid[g]=0 and clear on valid. At WATCHDOG_CYCLES the block SHALL enter ABORT.
- ABORT: drive m_axis_tvalid=1, tlast=1, tkeep=1, tdata=0, tuser[0]=1, all s_axis_tready=0; abort_pulse=1 on entry cycle.
- On m_axis_tready: go to DRAIN.
- DRAIN: s_axis_tready[g]=1, m_axis_tvalid=0, discard beats until the port's tlast handshake, then IDLE.
REQ-019 Macro undefined: no ABORT/DRAIN logic; XFER stalls indefinitely; abort_pulse tied 0.

Verification
REQ-020 Port0 and port1 both valid from cycle 10, 2-beat packets each, m_axis_tready=1 -> port0 beats at 11-12, bubble at 13, port1 at 14-15, grant sequence 01,00,10.
REQ-021 s_ifg_delay port0=12, port1=20 -> ifg_delay reads 12 during port0 packet, then 20 from port1 grant.
REQ-022 m_axis_tready low for 3 cycles mid-packet -> tdata held, no beat lost, s_axis_tready[g]=0 for those 3 cycles.
REQ-023 Reset pulse during beat 4 of an 8-beat packet -> next cycle IDLE, grant=0, ifg_delay=12, rr_ptr=0.
REQ-024 With IPG_ARB_WATCHDOG_EN, port0 stalls 16 cycles mid-packet -> abort beat with tuser=1, tlast=1, abort_pulse once; the remaining port0 beats are dropped; then port1 is served.
